// File: rtl/psg_pkg.sv
// Shared constants for the PSG register file: register indices, write masks and bus modes.
package psg_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned TONE_W   = 12;
    localparam int unsigned NOISE_W  = 5;
    localparam int unsigned MIXER_W  = 6;
    localparam int unsigned AMP_W    = 5;
    localparam int unsigned COARSE_W = 4;
    localparam int unsigned SHAPE_W  = 4;
    localparam int unsigned ENVP_W   = 16;

    typedef enum logic [1:0] {
        BUS_INACTIVE = 2'b00,
        BUS_READ     = 2'b01,
        BUS_WRITE    = 2'b10,
        BUS_LATCH    = 2'b11
    } bus_mode_e;

    localparam logic [IDX_W-1:0] REG_TONE_A_FINE   = 4'd0;
    localparam logic [IDX_W-1:0] REG_TONE_A_COARSE = 4'd1;
    localparam logic [IDX_W-1:0] REG_TONE_B_FINE   = 4'd2;
    localparam logic [IDX_W-1:0] REG_TONE_B_COARSE = 4'd3;
    localparam logic [IDX_W-1:0] REG_TONE_C_FINE   = 4'd4;
    localparam logic [IDX_W-1:0] REG_TONE_C_COARSE = 4'd5;
    localparam logic [IDX_W-1:0] REG_NOISE_PERIOD  = 4'd6;
    localparam logic [IDX_W-1:0] REG_MIXER         = 4'd7;
    localparam logic [IDX_W-1:0] REG_AMP_A         = 4'd8;
    localparam logic [IDX_W-1:0] REG_AMP_B         = 4'd9;
    localparam logic [IDX_W-1:0] REG_AMP_C         = 4'd10;
    localparam logic [IDX_W-1:0] REG_ENV_FINE      = 4'd11;
    localparam logic [IDX_W-1:0] REG_ENV_COARSE    = 4'd12;
    localparam logic [IDX_W-1:0] REG_ENV_SHAPE     = 4'd13;
    localparam logic [IDX_W-1:0] REG_IO_A          = 4'd14;
    localparam logic [IDX_W-1:0] REG_IO_B          = 4'd15;

    localparam logic [DATA_W-1:0] MASK_TONE_COARSE = 8'h0F;
    localparam logic [DATA_W-1:0] MASK_NOISE       = 8'h1F;
    localparam logic [DATA_W-1:0] MASK_MIXER       = 8'h3F;
    localparam logic [DATA_W-1:0] MASK_AMP         = 8'h1F;
    localparam logic [DATA_W-1:0] MASK_ENV_SHAPE   = 8'h0F;
    localparam logic [DATA_W-1:0] MASK_FULL        = 8'hFF;

    // Bits of each register that are actually implemented.
    function automatic logic [DATA_W-1:0] reg_mask(input logic [IDX_W-1:0] idx);
        case (idx)
            REG_TONE_A_COARSE, REG_TONE_B_COARSE, REG_TONE_C_COARSE: reg_mask = MASK_TONE_COARSE;
            REG_NOISE_PERIOD:                                        reg_mask = MASK_NOISE;
            REG_MIXER:                                               reg_mask = MASK_MIXER;
            REG_AMP_A, REG_AMP_B, REG_AMP_C:                         reg_mask = MASK_AMP;
            REG_ENV_SHAPE:                                           reg_mask = MASK_ENV_SHAPE;
            default:                                                 reg_mask = MASK_FULL;
        endcase
    endfunction

endpackage

// File: rtl/psg_bus_decode.sv
// BDIR/BC1 mode decoder: one strobe on the first cycle of each new bus mode.
// PSG_READBACK_EN adds the read strobe; without it read mode decodes as inactive.
module psg_bus_decode
    import psg_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_bdir,
    input  logic i_bc1,
    output logic o_latch_stb_c,
    output logic o_write_stb_c
`ifdef PSG_READBACK_EN
    ,
    output logic o_read_stb_c,
    output logic o_read_mode_c
`endif
);

    bus_mode_e w_mode;
    bus_mode_e r_prev_mode;
    logic      w_edge;

    always_comb begin
        w_mode = bus_mode_e'({i_bdir, i_bc1});
`ifndef PSG_READBACK_EN
        if (w_mode == BUS_READ) begin
            w_mode = BUS_INACTIVE;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev_mode <= BUS_INACTIVE;
        end else begin
            r_prev_mode <= w_mode;
        end
    end

    // Reset cycle never acts, so a burst interrupted by reset restarts cleanly.
    assign w_edge        = (w_mode != r_prev_mode) && !i_reset;
    assign o_latch_stb_c = w_edge && (w_mode == BUS_LATCH);
    assign o_write_stb_c = w_edge && (w_mode == BUS_WRITE);
`ifdef PSG_READBACK_EN
    assign o_read_stb_c  = w_edge && (w_mode == BUS_READ);
    assign o_read_mode_c = (w_mode == BUS_READ) && !i_reset;
`endif

endmodule

// File: rtl/psg_register_file.sv
// AY-3-8913 PSG bus interface and programmer-visible register bank.
// PSG_READBACK_EN enables the data_out/data_oe read path.
module psg_register_file
    import psg_pkg::*;
#(
    parameter logic [3:0] ADDRESS_MASK = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bdir,
    input  logic        bc1,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [11:0] tone_period_a,
    output logic [11:0] tone_period_b,
    output logic [11:0] tone_period_c,
    output logic [4:0]  noise_period,
    output logic [2:0]  tone_disable,
    output logic [2:0]  noise_disable,
    output logic [4:0]  amplitude_a,
    output logic [4:0]  amplitude_b,
    output logic [4:0]  amplitude_c,
    output logic [15:0] envelope_period,
    output logic [3:0]  envelope_shape,
    output logic        envelope_restart
);

    logic                w_latch_stb;
    logic                w_write_stb;
    logic                w_sel;
    logic                w_wr;
    logic [IDX_W-1:0]    w_idx;
    logic [DATA_W-1:0]   w_wdata;

    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_fine_a, r_fine_b, r_fine_c;
    logic [COARSE_W-1:0] r_coarse_a, r_coarse_b, r_coarse_c;
    logic [NOISE_W-1:0]  r_noise;
    logic [MIXER_W-1:0]  r_mixer;
    logic [AMP_W-1:0]    r_amp_a, r_amp_b, r_amp_c;
    logic [DATA_W-1:0]   r_env_fine, r_env_coarse;
    logic [SHAPE_W-1:0]  r_env_shape;
    logic                r_env_restart;

`ifdef PSG_READBACK_EN
    logic                w_read_stb;
    logic                w_read_mode;
`endif

    psg_bus_decode u_bus_decode (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_bdir        (bdir),
        .i_bc1         (bc1),
        .o_latch_stb_c (w_latch_stb),
        .o_write_stb_c (w_write_stb)
`ifdef PSG_READBACK_EN
        ,
        .o_read_stb_c  (w_read_stb),
        .o_read_mode_c (w_read_mode)
`endif
    );

    assign w_sel   = (r_addr[7:4] == ADDRESS_MASK);
    assign w_idx   = r_addr[3:0];
    assign w_wdata = data_in & reg_mask(w_idx);
    assign w_wr    = w_write_stb && w_sel;

    // Address latch and register writes; R14/R15 have no storage on the 8913.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr        <= '0;
            r_fine_a      <= '0;
            r_fine_b      <= '0;
            r_fine_c      <= '0;
            r_coarse_a    <= '0;
            r_coarse_b    <= '0;
            r_coarse_c    <= '0;
            r_noise       <= '0;
            r_mixer       <= '0;
            r_amp_a       <= '0;
            r_amp_b       <= '0;
            r_amp_c       <= '0;
            r_env_fine    <= '0;
            r_env_coarse  <= '0;
            r_env_shape   <= '0;
            r_env_restart <= 1'b0;
        end else begin
            r_env_restart <= 1'b0;
            if (w_latch_stb) begin
                r_addr <= data_in;
            end
            if (w_wr) begin
                case (w_idx)
                    REG_TONE_A_FINE:   r_fine_a     <= w_wdata;
                    REG_TONE_A_COARSE: r_coarse_a   <= w_wdata[COARSE_W-1:0];
                    REG_TONE_B_FINE:   r_fine_b     <= w_wdata;
                    REG_TONE_B_COARSE: r_coarse_b   <= w_wdata[COARSE_W-1:0];
                    REG_TONE_C_FINE:   r_fine_c     <= w_wdata;
                    REG_TONE_C_COARSE: r_coarse_c   <= w_wdata[COARSE_W-1:0];
                    REG_NOISE_PERIOD:  r_noise      <= w_wdata[NOISE_W-1:0];
                    REG_MIXER:         r_mixer      <= w_wdata[MIXER_W-1:0];
                    REG_AMP_A:         r_amp_a      <= w_wdata[AMP_W-1:0];
                    REG_AMP_B:         r_amp_b      <= w_wdata[AMP_W-1:0];
                    REG_AMP_C:         r_amp_c      <= w_wdata[AMP_W-1:0];
                    REG_ENV_FINE:      r_env_fine   <= w_wdata;
                    REG_ENV_COARSE:    r_env_coarse <= w_wdata;
                    REG_ENV_SHAPE: begin
                        r_env_shape   <= w_wdata[SHAPE_W-1:0];
                        r_env_restart <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PSG_READBACK_EN
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_oe;

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            REG_TONE_A_FINE:   w_rdata = r_fine_a;
            REG_TONE_A_COARSE: w_rdata = DATA_W'(r_coarse_a);
            REG_TONE_B_FINE:   w_rdata = r_fine_b;
            REG_TONE_B_COARSE: w_rdata = DATA_W'(r_coarse_b);
            REG_TONE_C_FINE:   w_rdata = r_fine_c;
            REG_TONE_C_COARSE: w_rdata = DATA_W'(r_coarse_c);
            REG_NOISE_PERIOD:  w_rdata = DATA_W'(r_noise);
            REG_MIXER:         w_rdata = DATA_W'(r_mixer);
            REG_AMP_A:         w_rdata = DATA_W'(r_amp_a);
            REG_AMP_B:         w_rdata = DATA_W'(r_amp_b);
            REG_AMP_C:         w_rdata = DATA_W'(r_amp_c);
            REG_ENV_FINE:      w_rdata = r_env_fine;
            REG_ENV_COARSE:    w_rdata = r_env_coarse;
            REG_ENV_SHAPE:     w_rdata = DATA_W'(r_env_shape);
            REG_IO_A, REG_IO_B: w_rdata = '0;
            default:           w_rdata = '0;
        endcase
    end

    // Selection is decided on the read edge and held while the bus stays in read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= '0;
            r_data_oe  <= 1'b0;
        end else if (w_read_mode && (w_read_stb ? w_sel : r_data_oe)) begin
            r_data_out <= w_rdata;
            r_data_oe  <= 1'b1;
        end else begin
            r_data_out <= '0;
            r_data_oe  <= 1'b0;
        end
    end

    assign data_out = r_data_out;
    assign data_oe  = r_data_oe;
`else
    assign data_out = 8'h00;
    assign data_oe  = 1'b0;
`endif

    assign tone_period_a    = {r_coarse_a, r_fine_a};
    assign tone_period_b    = {r_coarse_b, r_fine_b};
    assign tone_period_c    = {r_coarse_c, r_fine_c};
    assign noise_period     = r_noise;
    assign tone_disable     = r_mixer[2:0];
    assign noise_disable    = r_mixer[5:3];
    assign amplitude_a      = r_amp_a;
    assign amplitude_b      = r_amp_b;
    assign amplitude_c      = r_amp_c;
    assign envelope_period  = {r_env_coarse, r_env_fine};
    assign envelope_shape   = r_env_shape;
    assign envelope_restart = r_env_restart;

endmodule

// File: tb/tb_psg_register_file.sv
// Directed table-driven bench for psg_register_file (both readback builds).
module tb_psg_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        bdir;
    logic        bc1;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [11:0] tone_period_a, tone_period_b, tone_period_c;
    logic [4:0]  noise_period;
    logic [2:0]  tone_disable, noise_disable;
    logic [4:0]  amplitude_a, amplitude_b, amplitude_c;
    logic [15:0] envelope_period;
    logic [3:0]  envelope_shape;
    logic        envelope_restart;

    int checks = 0;
    int errors = 0;

`ifdef PSG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    localparam int S_NONE = 0, S_TONE_A = 1, S_TONE_B = 2, S_TONE_C = 3, S_NOISE = 4;
    localparam int S_MIXER = 5, S_AMP_A = 6, S_AMP_B = 7, S_AMP_C = 8, S_ENVP = 9;
    localparam int S_SHAPE = 10, S_RESTART = 11, S_DOUT = 12, S_DOE = 13;

    string sel_name [14] = '{"none", "tone_a", "tone_b", "tone_c", "noise", "mixer",
                             "amp_a", "amp_b", "amp_c", "env_period", "env_shape",
                             "env_restart", "data_out", "data_oe"};

    typedef struct {
        logic        rst;
        logic [1:0]  mode;
        logic [7:0]  din;
        int          sel_a;
        logic [15:0] exp_a;
        int          sel_b;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs[$];

    psg_register_file dut (
        .clk              (clk),
        .reset            (reset),
        .bdir             (bdir),
        .bc1              (bc1),
        .data_in          (data_in),
        .data_out         (data_out),
        .data_oe          (data_oe),
        .tone_period_a    (tone_period_a),
        .tone_period_b    (tone_period_b),
        .tone_period_c    (tone_period_c),
        .noise_period     (noise_period),
        .tone_disable     (tone_disable),
        .noise_disable    (noise_disable),
        .amplitude_a      (amplitude_a),
        .amplitude_b      (amplitude_b),
        .amplitude_c      (amplitude_c),
        .envelope_period  (envelope_period),
        .envelope_shape   (envelope_shape),
        .envelope_restart (envelope_restart)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] get_out(input int sel);
        case (sel)
            S_TONE_A:  return 16'(tone_period_a);
            S_TONE_B:  return 16'(tone_period_b);
            S_TONE_C:  return 16'(tone_period_c);
            S_NOISE:   return 16'(noise_period);
            S_MIXER:   return 16'({noise_disable, tone_disable});
            S_AMP_A:   return 16'(amplitude_a);
            S_AMP_B:   return 16'(amplitude_b);
            S_AMP_C:   return 16'(amplitude_c);
            S_ENVP:    return envelope_period;
            S_SHAPE:   return 16'(envelope_shape);
            S_RESTART: return 16'(envelope_restart);
            S_DOUT:    return 16'(data_out);
            S_DOE:     return 16'(data_oe);
            default:   return 16'h0000;
        endcase
    endfunction

    function automatic vec_t mk(input logic r, input logic [1:0] m, input logic [7:0] d,
                                input int sa, input logic [15:0] ea,
                                input int sb, input logic [15:0] eb);
        vec_t v;
        v.rst = r; v.mode = m; v.din = d;
        v.sel_a = sa; v.exp_a = ea; v.sel_b = sb; v.exp_b = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] m, input logic [7:0] d);
        reset = r;
        {bdir, bc1} = m;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rb(input logic [15:0] v);
        return RB ? v : 16'h0000;
    endfunction

    initial begin
        reset = 1'b1;
        bdir = 1'b0;
        bc1 = 1'b0;
        data_in = 8'h00;

        vecs.push_back(mk(1, 2'b00, 8'h00, S_TONE_A, 16'h000, S_RESTART, 16'h0));
        vecs.push_back(mk(1, 2'b00, 8'h00, S_MIXER, 16'h00, S_DOE, 16'h0));
        vecs.push_back(mk(0, 2'b11, 8'h00, S_TONE_A, 16'h000, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b10, 8'hAB, S_TONE_A, 16'h0AB, S_RESTART, 16'h0));
        vecs.push_back(mk(0, 2'b11, 8'h01, S_TONE_A, 16'h0AB, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b10, 8'hFF, S_TONE_A, 16'hFAB, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b00, 8'h00, S_TONE_A, 16'hFAB, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b11, 8'h0D, S_SHAPE, 16'h0, S_RESTART, 16'h0));
        vecs.push_back(mk(0, 2'b10, 8'h0E, S_SHAPE, 16'hE, S_RESTART, 16'h1));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 2'b10, 8'h0E, S_RESTART, 16'h0, S_SHAPE, 16'hE));
        vecs.push_back(mk(0, 2'b00, 8'h00, S_RESTART, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b10, 8'h0E, S_RESTART, 16'h1, S_SHAPE, 16'hE));
        vecs.push_back(mk(0, 2'b00, 8'h00, S_RESTART, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b11, 8'h17, S_NONE, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b10, 8'h55, S_RESTART, 16'h0, S_MIXER, 16'h00));
        vecs.push_back(mk(0, 2'b00, 8'h00, S_TONE_A, 16'hFAB, S_MIXER, 16'h00));
        vecs.push_back(mk(0, 2'b01, 8'h00, S_DOE, 16'h0, S_DOUT, 16'h00));
        vecs.push_back(mk(0, 2'b00, 8'h00, S_DOE, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b11, 8'h07, S_NONE, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b10, 8'hFF, S_MIXER, 16'h3F, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b01, 8'h00, S_DOUT, rb(16'h3F), S_DOE, rb(16'h1)));
        vecs.push_back(mk(0, 2'b01, 8'h00, S_DOUT, rb(16'h3F), S_DOE, rb(16'h1)));
        vecs.push_back(mk(0, 2'b00, 8'h00, S_DOE, 16'h0, S_DOUT, 16'h00));
        vecs.push_back(mk(0, 2'b11, 8'h0E, S_NONE, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b01, 8'h00, S_DOE, rb(16'h1), S_DOUT, 16'h00));
        vecs.push_back(mk(0, 2'b00, 8'h00, S_NONE, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b11, 8'h02, S_NONE, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b10, 8'h34, S_TONE_B, 16'h034, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b01, 8'h00, S_DOUT, rb(16'h34), S_DOE, rb(16'h1)));
        vecs.push_back(mk(0, 2'b11, 8'h03, S_NONE, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b10, 8'hA7, S_TONE_B, 16'h734, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b11, 8'h05, S_NONE, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b10, 8'hFF, S_TONE_C, 16'hF00, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b11, 8'h06, S_NONE, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b10, 8'hFF, S_NOISE, 16'h1F, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b11, 8'h08, S_NONE, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b10, 8'hFF, S_AMP_A, 16'h1F, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b11, 8'h09, S_NONE, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b10, 8'h35, S_AMP_B, 16'h15, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b11, 8'h0A, S_NONE, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b10, 8'h10, S_AMP_C, 16'h10, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b11, 8'h0B, S_NONE, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b10, 8'h12, S_ENVP, 16'h0012, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b11, 8'h0C, S_NONE, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b10, 8'h34, S_ENVP, 16'h3412, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b11, 8'h0F, S_NONE, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b10, 8'h99, S_RESTART, 16'h0, S_NONE, 16'h0));
        vecs.push_back(mk(0, 2'b01, 8'h00, S_DOUT, 16'h00, S_DOE, rb(16'h1)));
        vecs.push_back(mk(0, 2'b00, 8'h00, S_DOE, 16'h0, S_NONE, 16'h0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].mode, vecs[i].din);
            if (vecs[i].sel_a != S_NONE)
                check($sformatf("vec%0d_%s", i, sel_name[vecs[i].sel_a]),
                      get_out(vecs[i].sel_a), vecs[i].exp_a);
            if (vecs[i].sel_b != S_NONE)
                check($sformatf("vec%0d_%s", i, sel_name[vecs[i].sel_b]),
                      get_out(vecs[i].sel_b), vecs[i].exp_b);
        end

        // Reset pulse in the middle of a write burst to R13.
        step(0, 2'b11, 8'h0D);
        step(0, 2'b10, 8'h05);
        check("burst_restart", 16'(envelope_restart), 16'h1);
        check("burst_shape", 16'(envelope_shape), 16'h5);
        step(1, 2'b10, 8'h05);
        check("rst_restart", 16'(envelope_restart), 16'h0);
        check("rst_shape", 16'(envelope_shape), 16'h0);
        check("rst_tone_a", 16'(tone_period_a), 16'h000);
        check("rst_tone_c", 16'(tone_period_c), 16'h000);
        check("rst_noise", 16'(noise_period), 16'h00);
        check("rst_mixer", 16'({noise_disable, tone_disable}), 16'h00);
        check("rst_amp_b", 16'(amplitude_b), 16'h00);
        check("rst_envp", envelope_period, 16'h0000);
        // Write mode still present after reset acts once, on the cleared address.
        step(0, 2'b10, 8'h05);
        check("post_rst_commit", 16'(tone_period_a), 16'h005);
        check("post_rst_restart", 16'(envelope_restart), 16'h0);
        step(0, 2'b10, 8'h12);
        check("post_rst_hold", 16'(tone_period_a), 16'h005);
        step(0, 2'b00, 8'h00);
        step(0, 2'b10, 8'h12);
        check("r0_rewrite", 16'(tone_period_a), 16'h012);
        step(0, 2'b01, 8'h00);
        check("r0_read_oe", 16'(data_oe), rb(16'h1));
        check("r0_read_dout", 16'(data_out), rb(16'h12));
        check("r0_read_tone", 16'(tone_period_a), 16'h012);
        step(0, 2'b00, 8'h00);
        check("r0_read_clear", 16'(data_oe), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
